// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: state encoding,
// counter width and the saturating increment used by the MEM streak counter.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t IF_ACC = 2'd1;
    localparam arb_state_t DM_ACC = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Loadable down-counter that stops at zero; done_o is high while the count is zero.
module mem_access_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage,
// running each access for LATENCY strobe cycles and stalling the side that waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    output logic                  arb_if_stall,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  arb_dm_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] MAX_STREAK = CNT_W'(MAX_DM_STREAK);

    arb_state_t            state_q,     state_d;
    logic [CNT_W-1:0]      streak_q,    streak_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;
    logic                  if_ready_q,  if_ready_d;
    logic                  dm_ready_q,  dm_ready_d;

    logic timer_load;
    logic timer_done;
    logic dm_req;
    logic arb_en;
    logic dm_wins;

    mem_access_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (timer_load),
        .value_i (LOAD_VAL),
        .done_o  (timer_done)
    );

    assign dm_req  = dm_read | dm_write;
    // Requests are held until ready is seen, so the cycle carrying a ready
    // pulse still shows the finished request; arbitration skips that cycle.
    assign arb_en  = (state_q == IDLE) && !if_ready_q && !dm_ready_q;
    assign dm_wins = dm_req && !(if_req && (streak_q == MAX_STREAK));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        timer_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_en && dm_wins) begin
                    state_d     = DM_ACC;
                    timer_load  = 1'b1;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_write_d = dm_write;
                    mem_read_d  = dm_read & ~dm_write;
                    streak_d    = if_req ? sat_inc(streak_q) : '0;
                end else if (arb_en && if_req) begin
                    state_d     = IF_ACC;
                    timer_load  = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    streak_d    = '0;
                end
            end
            IF_ACC: begin
                if (timer_done) begin
                    state_d     = IDLE;
                    if_rdata_d  = mem_rdata;
                    if_ready_d  = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            DM_ACC: begin
                if (timer_done) begin
                    state_d     = IDLE;
                    if (mem_read_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_ready_d  = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_ready     = if_ready_q;
    assign dm_rdata     = dm_rdata_q;
    assign dm_ready     = dm_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign arb_if_stall = if_req & ~if_ready_q;
    assign arb_dm_stall = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle expectations written by hand
// for LATENCY=2, MAX_DM_STREAK=4; cycle 0 is the cycle a request is first driven.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        arb_if_stall;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        arb_dm_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .LATENCY       (2),
        .MAX_DM_STREAK (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .arb_if_stall (arb_if_stall),
        .dm_read      (dm_read),
        .dm_write     (dm_write),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ready     (dm_ready),
        .arb_dm_stall (arb_dm_stall),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:1] exp_mr;
    logic [7:1] exp_mw;
    logic [7:1] exp_dr;
    logic [7:1] exp_ir;
    int         ev_kind [6];
    int         ev_cyc  [6];
    int         exp_kind [6];
    int         exp_cyc  [6];
    int         nev;
    int         nready;

    initial begin
        exp_mr = 7'b0110000;
        exp_mw = 7'b0000011;
        exp_dr = 7'b0000100;
        exp_ir = 7'b1000000;
        exp_kind = '{0, 0, 0, 0, 1, 0};
        exp_cyc  = '{3, 7, 11, 15, 19, 23};

        // Reset held with a fetch pending
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h40;
        repeat (3) tick();
        chk("rst_if_rdata",  if_rdata,     0);
        chk("rst_if_ready",  if_ready,     0);
        chk("rst_dm_rdata",  dm_rdata,     0);
        chk("rst_dm_ready",  dm_ready,     0);
        chk("rst_mem_addr",  mem_addr,     0);
        chk("rst_mem_wdata", mem_wdata,    0);
        chk("rst_mem_read",  mem_read,     0);
        chk("rst_mem_write", mem_write,    0);
        chk("rst_if_stall",  arb_if_stall, 1);
        chk("rst_dm_stall",  arb_dm_stall, 0);

        // Lone fetch
        reset     = 1'b1;
        mem_rdata = 32'h8C010004;
        tick();
        chk("lf_c1_mem_read", mem_read,     1);
        chk("lf_c1_mem_addr", mem_addr,     32'h40);
        chk("lf_c1_mem_wr",   mem_write,    0);
        chk("lf_c1_if_ready", if_ready,     0);
        chk("lf_c1_stall",    arb_if_stall, 1);
        tick();
        chk("lf_c2_mem_read", mem_read,     1);
        chk("lf_c2_mem_addr", mem_addr,     32'h40);
        tick();
        chk("lf_c3_if_ready", if_ready,     1);
        chk("lf_c3_if_rdata", if_rdata,     32'h8C010004);
        chk("lf_c3_mem_read", mem_read,     0);
        chk("lf_c3_stall",    arb_if_stall, 0);
        if_req = 1'b0;
        tick();
        chk("lf_c4_if_ready", if_ready,     0);
        chk("lf_c4_hold",     if_rdata,     32'h8C010004);

        // Collision: store and fetch rise together
        if_req    = 1'b1;
        if_addr   = 32'h80;
        dm_write  = 1'b1;
        dm_addr   = 32'h100;
        dm_wdata  = 32'hDEADBEEF;
        mem_rdata = 32'h11223344;
        #1;
        chk("col_c0_dm_stall", arb_dm_stall, 1);
        chk("col_c0_if_stall", arb_if_stall, 1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("col_c%0d_mem_read", c),  mem_read,  exp_mr[c]);
            chk($sformatf("col_c%0d_mem_write", c), mem_write, exp_mw[c]);
            chk($sformatf("col_c%0d_dm_ready", c),  dm_ready,  exp_dr[c]);
            chk($sformatf("col_c%0d_if_ready", c),  if_ready,  exp_ir[c]);
            if (c == 1 || c == 2) begin
                chk($sformatf("col_c%0d_mem_addr", c),  mem_addr,  32'h100);
                chk($sformatf("col_c%0d_mem_wdata", c), mem_wdata, 32'hDEADBEEF);
            end
            if (c == 5 || c == 6) begin
                chk($sformatf("col_c%0d_if_addr", c), mem_addr, 32'h80);
            end
            if (c == 3) begin
                chk("col_c3_dm_rdata", dm_rdata, 0);
                dm_write = 1'b0;
            end
            if (c == 7) begin
                chk("col_c7_if_rdata", if_rdata, 32'h11223344);
                if_req = 1'b0;
            end
        end

        // Starvation limit: loads held continuously against a pending fetch
        tick();
        dm_read   = 1'b1;
        dm_addr   = 32'h200;
        if_req    = 1'b1;
        if_addr   = 32'h300;
        mem_rdata = 32'hCAFEF00D;
        nev = 0;
        for (int c = 1; c <= 40 && nev < 6; c++) begin
            tick();
            if (dm_ready) begin
                ev_kind[nev] = 0;
                ev_cyc[nev]  = c;
                nev++;
            end else if (if_ready) begin
                ev_kind[nev] = 1;
                ev_cyc[nev]  = c;
                nev++;
            end
        end
        chk("stv_event_count", nev, 6);
        for (int i = 0; i < nev; i++) begin
            chk($sformatf("stv_ev%0d_kind", i),  ev_kind[i], exp_kind[i]);
            chk($sformatf("stv_ev%0d_cycle", i), ev_cyc[i],  exp_cyc[i]);
        end
        chk("stv_dm_rdata", dm_rdata, 32'hCAFEF00D);
        chk("stv_if_rdata", if_rdata, 32'hCAFEF00D);
        dm_read = 1'b0;
        if_req  = 1'b0;

        // Reset in cycle 2 of a store
        tick();
        dm_write = 1'b1;
        dm_addr  = 32'h140;
        dm_wdata = 32'h12345678;
        tick();
        chk("rma_c1_mem_write", mem_write, 1);
        tick();
        chk("rma_c2_mem_write", mem_write, 1);
        reset    = 1'b0;
        dm_write = 1'b0;
        #1;
        chk("rma_mem_write_drop", mem_write, 0);
        chk("rma_mem_addr",       mem_addr,  0);
        chk("rma_mem_wdata",      mem_wdata, 0);
        chk("rma_dm_rdata",       dm_rdata,  0);
        chk("rma_if_rdata",       if_rdata,  0);
        tick();
        reset  = 1'b1;
        nready = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (dm_ready) nready++;
        end
        chk("rma_no_dm_ready", nready, 0);

        // Fetch after reset proves the arbiter came back to IDLE
        if_req    = 1'b1;
        if_addr   = 32'h44;
        mem_rdata = 32'h00001234;
        tick();
        chk("prf_c1_mem_read", mem_read, 1);
        chk("prf_c1_mem_addr", mem_addr, 32'h44);
        tick();
        tick();
        chk("prf_c3_if_ready", if_ready, 1);
        chk("prf_c3_if_rdata", if_rdata, 32'h00001234);
        if_req = 1'b0;

        // Plain load, then dual-flag access behaves as a store
        tick();
        dm_read   = 1'b1;
        dm_addr   = 32'h180;
        mem_rdata = 32'h0BADC0DE;
        tick();
        chk("ld_c1_mem_read",  mem_read,  1);
        chk("ld_c1_mem_write", mem_write, 0);
        chk("ld_c1_mem_addr",  mem_addr,  32'h180);
        tick();
        tick();
        chk("ld_c3_dm_ready", dm_ready, 1);
        chk("ld_c3_dm_rdata", dm_rdata, 32'h0BADC0DE);
        dm_read = 1'b0;
        tick();
        dm_read   = 1'b1;
        dm_write  = 1'b1;
        dm_addr   = 32'h1C0;
        dm_wdata  = 32'hA5A5A5A5;
        mem_rdata = 32'h55555555;
        tick();
        chk("dual_c1_mem_write", mem_write, 1);
        chk("dual_c1_mem_read",  mem_read,  0);
        chk("dual_c1_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        tick();
        chk("dual_c3_dm_ready", dm_ready, 1);
        chk("dual_c3_dm_rdata", dm_rdata, 32'h0BADC0DE);
        dm_read  = 1'b0;
        dm_write = 1'b0;
        tick();
        chk("dual_c4_dm_ready", dm_ready, 0);
        chk("dual_c4_strobes",  {mem_read, mem_write}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
